// File: rtl/mem_dump_tx_pkg.sv
// Shared definitions for the debug-unit data-memory dump path.
package mem_dump_tx_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_LATCH     = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT      = 3'd4,
        ST_DONE      = 3'd5,
        ST_CSUM_SEND = 3'd6,
        ST_CSUM_WAIT = 3'd7
    } state_e;

    function automatic int unsigned bytes_per_word(input int unsigned n_bits);
        return n_bits / BYTE_W;
    endfunction

endpackage

// File: rtl/mem_dump_word_ser.sv
// Word latch plus MSB-first byte shifter; last_o flags the final byte of the word.
module mem_dump_word_ser
    import mem_dump_tx_pkg::*;
#(
    parameter int unsigned N_BITS = 32
)
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                load_i,
    input  logic [N_BITS-1:0]   load_data_i,
    input  logic                shift_i,
    output logic [BYTE_W-1:0]   byte_o,
    output logic                last_o
);

    localparam int unsigned BPW   = bytes_per_word(N_BITS);
    localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [N_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // Load wins over shift; the top never asserts both in one cycle.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (load_i) begin
            shift_d = load_data_i;
            idx_d   = '0;
        end else if (shift_i) begin
            shift_d = shift_q << BYTE_W;
            idx_d   = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign byte_o = shift_q[N_BITS-1 -: BYTE_W];
    assign last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/mem_dump_tx.sv
// Walks data memory 0..N_WORDS-1 and streams each word MSB-first to the UART TX.
// Optional trailing XOR checksum byte when MEM_DUMP_CHECKSUM_EN is defined.
module mem_dump_tx
    import mem_dump_tx_pkg::*;
#(
    parameter int unsigned N_BITS  = 32,
    parameter int unsigned N_WORDS = 32,
    parameter int unsigned ADDR_W  = 5
)
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    output logic                o_mem_rd_en,
    output logic [N_BITS-1:0]   o_mem_addr,
    input  logic [N_BITS-1:0]   i_mem_data,
    output logic [BYTE_W-1:0]   o_tx_data,
    output logic                o_tx_start,
    input  logic                i_tx_done,
    output logic                o_busy,
    output logic                o_done
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   word_q;
    logic                rd_en_q;
    logic                tx_start_q;
    logic                busy_q;
    logic                done_q;

    logic                ser_load;
    logic                ser_shift;
    logic [N_BITS-1:0]   ser_load_data;
    logic [BYTE_W-1:0]   ser_byte;
    logic                ser_last;
    logic                last_word_c;
    logic                csum_load_c;

    assign last_word_c = (word_q == LAST_WORD);

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [BYTE_W-1:0]   csum_q;
    logic [BYTE_W-1:0]   csum_next_c;

    // The checksum byte reuses the shifter so o_tx_data stays a flop output.
    assign csum_next_c   = csum_q ^ ser_byte;
    assign csum_load_c   = (state_q == ST_WAIT) && i_tx_done && ser_last && last_word_c;
    assign ser_load_data = csum_load_c ? (N_BITS'(csum_next_c) << (N_BITS - BYTE_W)) : i_mem_data;
`else
    assign csum_load_c   = 1'b0;
    assign ser_load_data = i_mem_data;
`endif

    assign ser_load  = (state_q == ST_LATCH) || csum_load_c;
    assign ser_shift = (state_q == ST_WAIT) && i_tx_done && !ser_last;

    mem_dump_word_ser #(
        .N_BITS      (N_BITS)
    ) u_ser (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .load_i      (ser_load),
        .load_data_i (ser_load_data),
        .shift_i     (ser_shift),
        .byte_o      (ser_byte),
        .last_o      (ser_last)
    );

    // Pulse outputs are set on the transition into the state that owns them.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            rd_en_q    <= 1'b0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            rd_en_q    <= 1'b0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q <= ST_READ;
                        word_q  <= '0;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                ST_READ:  state_q <= ST_LATCH;
                ST_LATCH: begin
                    state_q    <= ST_SEND;
                    tx_start_q <= 1'b1;
                end
                ST_SEND:  state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (i_tx_done) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                        csum_q <= csum_next_c;
`endif
                        if (!ser_last) begin
                            state_q    <= ST_SEND;
                            tx_start_q <= 1'b1;
                        end else if (!last_word_c) begin
                            word_q  <= word_q + ADDR_W'(1);
                            state_q <= ST_READ;
                            rd_en_q <= 1'b1;
                        end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
                            state_q    <= ST_CSUM_SEND;
                            tx_start_q <= 1'b1;
`else
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef MEM_DUMP_CHECKSUM_EN
                ST_CSUM_SEND: state_q <= ST_CSUM_WAIT;
                ST_CSUM_WAIT: begin
                    if (i_tx_done) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_rd_en = rd_en_q;
    assign o_mem_addr  = N_BITS'(word_q);
    assign o_tx_data   = ser_byte;
    assign o_tx_start  = tx_start_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx: a 2-word instance for handshake/timing corner cases and a
// default 32-word instance for full walks with randomized contents and TX latency.
`timescale 1ns/1ps
module tb_mem_dump_tx;

    typedef logic [7:0] byte_q_t [$];
    typedef logic [31:0] addr_q_t [$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // ---------------- instance A: N_WORDS = 2 ----------------
    logic        start_a, rd_en_a, tx_start_a, busy_a, done_a, tx_done_a;
    logic        spur_a = 1'b0;
    logic        model_done_a = 1'b0;
    logic [31:0] addr_a;
    logic [31:0] rdata_a = '0;
    logic [7:0]  txd_a;
    logic [31:0] mem_a [32];
    int          wait_a = -1;
    int          delay_a = 9;
    int          done_cnt_a = 0;
    byte_q_t     log_a;

    mem_dump_tx #(.N_BITS(32), .N_WORDS(2), .ADDR_W(5)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_start(start_a),
        .o_mem_rd_en(rd_en_a), .o_mem_addr(addr_a), .i_mem_data(rdata_a),
        .o_tx_data(txd_a), .o_tx_start(tx_start_a), .i_tx_done(tx_done_a),
        .o_busy(busy_a), .o_done(done_a)
    );
    assign tx_done_a = model_done_a | spur_a;

    always @(posedge clk) if (rd_en_a) rdata_a <= mem_a[addr_a[4:0]];

    always @(negedge clk) begin
        model_done_a <= 1'b0;
        if (done_a) done_cnt_a++;
        if (rst) wait_a = -1;
        else if (tx_start_a) begin
            log_a.push_back(txd_a);
            wait_a = delay_a;
        end else if (wait_a == 0) begin
            model_done_a <= 1'b1;
            wait_a = -1;
        end else if (wait_a > 0) wait_a--;
    end

    // ---------------- instance B: default N_WORDS = 32 ----------------
    logic        start_b, rd_en_b, tx_start_b, busy_b, done_b;
    logic        model_done_b = 1'b0;
    logic [31:0] addr_b;
    logic [31:0] rdata_b = '0;
    logic [7:0]  txd_b;
    logic [31:0] mem_b [32];
    int          wait_b = -1;
    int          delay_b = 0;
    int          done_cnt_b = 0;
    byte_q_t     log_b;
    addr_q_t     alog_b;

    mem_dump_tx dut_b (
        .i_clk(clk), .i_reset(rst), .i_start(start_b),
        .o_mem_rd_en(rd_en_b), .o_mem_addr(addr_b), .i_mem_data(rdata_b),
        .o_tx_data(txd_b), .o_tx_start(tx_start_b), .i_tx_done(model_done_b),
        .o_busy(busy_b), .o_done(done_b)
    );

    always @(posedge clk) if (rd_en_b) rdata_b <= mem_b[addr_b[4:0]];

    // delay_b < 0 selects a fresh random latency for every byte
    always @(negedge clk) begin
        model_done_b <= 1'b0;
        if (done_b) done_cnt_b++;
        if (rd_en_b) alog_b.push_back(addr_b);
        if (rst) wait_b = -1;
        else if (tx_start_b) begin
            log_b.push_back(txd_b);
            wait_b = (delay_b < 0) ? int'($urandom_range(0, 5)) : delay_b;
        end else if (wait_b == 0) begin
            model_done_b <= 1'b1;
            wait_b = -1;
        end else if (wait_b > 0) wait_b--;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference stream: words in address order, big-endian bytes, optional XOR tail.
    task automatic build_exp(input logic [31:0] words [32], input int n, output byte_q_t q);
        logic [7:0] x;
        logic [7:0] b;
        q = {};
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = words[w][31 - 8*k -: 8];
                q.push_back(b);
                x = x ^ b;
            end
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        q.push_back(x);
`endif
    endtask

    task automatic check_bytes(input string tag, input byte_q_t got, input int base, input byte_q_t exp);
        logic [7:0] v;
        chk({tag, "_count"}, 32'(got.size() - base), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            v = 8'hxx;
            if (base + i < got.size()) v = got[base + i];
            chk($sformatf("%s_byte%0d", tag, i), 32'(v), 32'(exp[i]));
        end
    endtask

    task automatic wait_idle(input string tag, input bit use_b, input int lim);
        logic b;
        b = 1'b1;
        for (int i = 0; i < lim; i++) begin
            step(1);
            b = use_b ? busy_b : busy_a;
            if (!b) break;
        end
        chk({tag, "_finished"}, 32'(b), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        byte_q_t    exp_a;
        byte_q_t    exp_b;
        int         base;
        int         dbase;
        int         abase;
        logic       found;
        logic [7:0] v;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        for (int k = 0; k < 32; k++) begin
            mem_a[k] = 32'h0;
            mem_b[k] = 32'(k);
        end
        mem_a[0] = 32'h1122_3344;
        mem_a[1] = 32'hAABB_CCDD;
        build_exp(mem_a, 2, exp_a);

        step(3);
        chk("rst_rd_en", 32'(rd_en_a), 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_tx_data", 32'(txd_a), 0);
        chk("rst_tx_start", 32'(tx_start_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        rst = 1'b0;
        step(2);

        // Latency and ordering: start sampled at edge t, rd_en at t+1, tx_start at t+3
        base = log_a.size(); dbase = done_cnt_a;
        start_a = 1'b1; step(1); start_a = 1'b0;
        chk("t1_rd_en", 32'(rd_en_a), 1);
        chk("t1_addr", addr_a, 0);
        chk("t1_busy", 32'(busy_a), 1);
        chk("t1_tx_start", 32'(tx_start_a), 0);
        step(1);
        chk("t2_rd_en", 32'(rd_en_a), 0);
        chk("t2_tx_start", 32'(tx_start_a), 0);
        step(1);
        chk("t3_tx_start", 32'(tx_start_a), 1);
        chk("t3_tx_data", 32'(txd_a), 32'h11);
        wait_idle("s1", 1'b0, 400);
        check_bytes("s1", log_a, base, exp_a);
`ifdef MEM_DUMP_CHECKSUM_EN
        v = 8'hxx;
        if (log_a.size() > base + 8) v = log_a[base + 8];
        chk("s1_csum", 32'(v), 32'h44);
`endif
        chk("s1_done_cnt", 32'(done_cnt_a - dbase), 1);
        chk("s1_busy_after", 32'(busy_a), 0);
        step(3);

        // Spurious done in READ/LATCH/SEND, start while busy and in the DONE cycle
        base = log_a.size(); dbase = done_cnt_a;
        start_a = 1'b1; step(1); start_a = 1'b0; spur_a = 1'b1;
        step(1);
        step(1); start_a = 1'b1;
        chk("s3_send_start", 32'(tx_start_a), 1);
        chk("s3_send_data", 32'(txd_a), 32'h11);
        step(1); spur_a = 1'b0; start_a = 1'b0;
        chk("s3_wait_hold", 32'(txd_a), 32'h11);
        chk("s3_wait_no_start", 32'(tx_start_a), 0);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (i == 30) start_a = 1'b1;
            if (i == 31) start_a = 1'b0;
            if (done_a) begin
                found = 1'b1;
                break;
            end
        end
        chk("s3_done_seen", 32'(found), 1);
        start_a = 1'b1; step(1); start_a = 1'b0;
        chk("s3_no_restart_busy", 32'(busy_a), 0);
        chk("s3_no_restart_rd", 32'(rd_en_a), 0);
        step(3);
        chk("s3_idle_busy", 32'(busy_a), 0);
        check_bytes("s3", log_a, base, exp_a);
        chk("s3_done_cnt", 32'(done_cnt_a - dbase), 1);

        // Reset while waiting on byte 3, then a clean dump from address 0
        base = log_a.size(); dbase = done_cnt_a;
        start_a = 1'b1; step(1); start_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (tx_start_a && txd_a == 8'h33) begin
                found = 1'b1;
                break;
            end
        end
        chk("s4_byte3_seen", 32'(found), 1);
        step(2);
        rst = 1'b1; step(1);
        chk("s4_rst_busy", 32'(busy_a), 0);
        chk("s4_rst_rd_en", 32'(rd_en_a), 0);
        chk("s4_rst_addr", addr_a, 0);
        chk("s4_rst_tx_start", 32'(tx_start_a), 0);
        chk("s4_rst_tx_data", 32'(txd_a), 0);
        chk("s4_rst_done", 32'(done_a), 0);
        step(1); rst = 1'b0;
        step(20);
        chk("s4_no_done", 32'(done_cnt_a - dbase), 0);
        chk("s4_bytes_before_rst", 32'(log_a.size() - base), 3);
        base = log_a.size(); dbase = done_cnt_a;
        start_a = 1'b1; step(1); start_a = 1'b0;
        chk("s4_restart_rd_en", 32'(rd_en_a), 1);
        chk("s4_restart_addr", addr_a, 0);
        wait_idle("s4", 1'b0, 400);
        check_bytes("s4", log_a, base, exp_a);
        chk("s4_done_cnt", 32'(done_cnt_a - dbase), 1);

        // Full 32-word walk, word k = k, immediate done
        build_exp(mem_b, 32, exp_b);
        base = log_b.size(); dbase = done_cnt_b; abase = alog_b.size();
        delay_b = 0;
        start_b = 1'b1; step(1); start_b = 1'b0;
        wait_idle("s5", 1'b1, 2000);
        check_bytes("s5", log_b, base, exp_b);
        chk("s5_addr_count", 32'(alog_b.size() - abase), 32);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("s5_addr%0d", k), (abase + k < alog_b.size()) ? alog_b[abase + k] : 32'hxxxx_xxxx, 32'(k));
        end
        for (int k = 0; k < 4; k++) begin
            v = 8'hxx;
            if (base + 124 + k < log_b.size()) v = log_b[base + 124 + k];
            chk($sformatf("s5_tail%0d", k), 32'(v), (k == 3) ? 32'h1F : 32'h00);
        end
        chk("s5_done_cnt", 32'(done_cnt_b - dbase), 1);

        // Random contents with random per-byte TX latency
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 32; k++) mem_b[k] = $urandom;
            build_exp(mem_b, 32, exp_b);
            base = log_b.size(); dbase = done_cnt_b;
            delay_b = -1;
            step(2);
            start_b = 1'b1; step(1); start_b = 1'b0;
            wait_idle($sformatf("rnd%0d", r), 1'b1, 6000);
            check_bytes($sformatf("rnd%0d", r), log_b, base, exp_b);
            chk($sformatf("rnd%0d_done_cnt", r), 32'(done_cnt_b - dbase), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
